// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: requester source codes
// and the per-slot record kept in the tag table.
package mem_arb_pkg;

    localparam logic SRC_LSQ   = 1'b0;
    localparam logic SRC_IF    = 1'b1;
    localparam int   MAX_TAGS  = 16;
    localparam int   ORIG_ID_W = 4;

    typedef struct packed {
        logic                 busy;
        logic                 src;
        logic [ORIG_ID_W-1:0] id;
    } slot_t;

endpackage

// File: rtl/mem_arb_tag_table.sv
// Outstanding-request slot table: lowest-free allocation, free on response and
// owner lookup by memory id.
module mem_arb_tag_table
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS = 8,
    parameter int ID_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic                 alloc_src,
    input  logic [ORIG_ID_W-1:0] alloc_orig_id,
    output logic [ID_W-1:0]      alloc_idx,
    output logic                 free_avail,
    input  logic                 free_en,
    input  logic [ID_W-1:0]      free_idx,
    input  logic [ID_W-1:0]      lookup_idx,
    output logic                 lookup_hit,
    output logic                 lookup_src,
    output logic [ORIG_ID_W-1:0] lookup_orig_id
);

    slot_t slot_q [NUM_TAGS];
    slot_t slot_d [NUM_TAGS];

    // Scan downward so the last match left standing is the lowest free index.
    always_comb begin
        free_avail = 1'b0;
        alloc_idx  = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!slot_q[i].busy) begin
                free_avail = 1'b1;
                alloc_idx  = ID_W'(i);
            end
        end
    end

    // Ids at or above NUM_TAGS match no slot and therefore report a miss.
    always_comb begin
        lookup_hit     = 1'b0;
        lookup_src     = SRC_LSQ;
        lookup_orig_id = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (ID_W'(i) == lookup_idx) begin
                lookup_hit     = slot_q[i].busy;
                lookup_src     = slot_q[i].src;
                lookup_orig_id = slot_q[i].id;
            end
        end
    end

    always_comb begin
        slot_d = slot_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (free_en && free_idx == ID_W'(i)) begin
                slot_d[i] = '0;
            end
            if (alloc_en && alloc_idx == ID_W'(i)) begin
                slot_d[i] = '{busy: 1'b1, src: alloc_src, id: alloc_orig_id};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_system port between the LSQ and instruction fetch with tagged
// responses. Define MEM_ARB_RR_EN for round-robin arbitration (default: LSQ priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_TAGS = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsq_valid,
    input  logic              lsq_rw,
    input  logic [ADDR_W-1:0] lsq_addr,
    input  logic [DATA_W-1:0] lsq_wdata,
    input  logic [ID_W-1:0]   lsq_id,
    output logic              lsq_ready,
    output logic              lsq_rsp_valid,
    output logic [ID_W-1:0]   lsq_rsp_id,
    output logic [DATA_W-1:0] lsq_rsp_data,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    output logic [ID_W-1:0]   mem_id,
    output logic              mem_valid,
    input  logic              mem_stall,
    input  logic              mem_rsp_valid,
    input  logic [ID_W-1:0]   mem_rsp_id,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              err_spurious
);

    logic                 free_avail;
    logic [ID_W-1:0]      alloc_idx;
    logic                 lookup_hit;
    logic                 lookup_src;
    logic [ORIG_ID_W-1:0] lookup_orig_id;
    logic                 lsq_gnt;
    logic                 if_gnt;
    logic                 accept;
    logic                 rsp_hit;

    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ID_W-1:0]   mem_id_q, mem_id_d;
    logic              lsq_rsp_valid_q, lsq_rsp_valid_d;
    logic [ID_W-1:0]   lsq_rsp_id_q, lsq_rsp_id_d;
    logic [DATA_W-1:0] lsq_rsp_data_q, lsq_rsp_data_d;
    logic              if_rsp_valid_q, if_rsp_valid_d;
    logic [DATA_W-1:0] if_rsp_data_q, if_rsp_data_d;
    logic              err_q, err_d;

`ifdef MEM_ARB_RR_EN
    logic prio_q, prio_d;

    // The pointer names the requester that wins the next contested cycle.
    always_comb begin
        lsq_gnt = (lsq_valid && if_valid) ? (prio_q == SRC_LSQ) : lsq_valid;
        prio_d  = prio_q;
        if (accept) begin
            prio_d = lsq_ready ? SRC_IF : SRC_LSQ;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prio_q <= SRC_LSQ;
        else     prio_q <= prio_d;
    end
`else
    assign lsq_gnt = lsq_valid;
`endif

    assign if_gnt    = if_valid & ~lsq_gnt;
    assign lsq_ready = lsq_gnt & ~mem_stall & free_avail;
    assign if_ready  = if_gnt & ~mem_stall & free_avail;
    assign accept    = lsq_ready | if_ready;
    assign rsp_hit   = mem_rsp_valid & lookup_hit;

    mem_arb_tag_table #(
        .NUM_TAGS(NUM_TAGS),
        .ID_W    (ID_W)
    ) u_tag_table (
        .clk           (clk),
        .rst           (rst),
        .alloc_en      (accept),
        .alloc_src     (lsq_ready ? SRC_LSQ : SRC_IF),
        .alloc_orig_id (lsq_ready ? ORIG_ID_W'(lsq_id) : '0),
        .alloc_idx     (alloc_idx),
        .free_avail    (free_avail),
        .free_en       (rsp_hit),
        .free_idx      (mem_rsp_id),
        .lookup_idx    (mem_rsp_id),
        .lookup_hit    (lookup_hit),
        .lookup_src    (lookup_src),
        .lookup_orig_id(lookup_orig_id)
    );

    // Issue stage: payload registers hold their last value when nothing issues.
    always_comb begin
        mem_valid_d = accept;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_id_d    = mem_id_q;
        if (accept) begin
            mem_addr_d  = lsq_ready ? lsq_addr : if_addr;
            mem_wdata_d = lsq_ready ? lsq_wdata : '0;
            mem_rw_d    = lsq_ready ? lsq_rw : 1'b0;
            mem_id_d    = alloc_idx;
        end
    end

    // Response stage: route to the owner; a miss is dropped and flagged stickily.
    always_comb begin
        lsq_rsp_valid_d = rsp_hit & (lookup_src == SRC_LSQ);
        if_rsp_valid_d  = rsp_hit & (lookup_src == SRC_IF);
        lsq_rsp_id_d    = lsq_rsp_id_q;
        lsq_rsp_data_d  = lsq_rsp_data_q;
        if_rsp_data_d   = if_rsp_data_q;
        if (lsq_rsp_valid_d) begin
            lsq_rsp_id_d   = ID_W'(lookup_orig_id);
            lsq_rsp_data_d = mem_rsp_data;
        end
        if (if_rsp_valid_d) begin
            if_rsp_data_d = mem_rsp_data;
        end
        err_d = err_q | (mem_rsp_valid & ~lookup_hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q     <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_rw_q        <= 1'b0;
            mem_id_q        <= '0;
            lsq_rsp_valid_q <= 1'b0;
            lsq_rsp_id_q    <= '0;
            lsq_rsp_data_q  <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= '0;
            err_q           <= 1'b0;
        end else begin
            mem_valid_q     <= mem_valid_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_rw_q        <= mem_rw_d;
            mem_id_q        <= mem_id_d;
            lsq_rsp_valid_q <= lsq_rsp_valid_d;
            lsq_rsp_id_q    <= lsq_rsp_id_d;
            lsq_rsp_data_q  <= lsq_rsp_data_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_rsp_data_q   <= if_rsp_data_d;
            err_q           <= err_d;
        end
    end

    assign mem_valid     = mem_valid_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_rw        = mem_rw_q;
    assign mem_id        = mem_id_q;
    assign lsq_rsp_valid = lsq_rsp_valid_q;
    assign lsq_rsp_id    = lsq_rsp_id_q;
    assign lsq_rsp_data  = lsq_rsp_data_q;
    assign if_rsp_valid  = if_rsp_valid_q;
    assign if_rsp_data   = if_rsp_data_q;
    assign err_spurious  = err_q;

endmodule
